// File: rtl/reg_file_sb_if.sv
// Register-file bus: read ports, ALU/load writeback, load issue, debug read and busy count.
// The design sits on the slave modport and decode/writeback logic on the master modport.
interface reg_file_sb_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
);
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic          rs_busy;
    logic          rt_busy;
    logic          w0_en;
    logic [AW-1:0] w0_addr;
    logic [DW-1:0] w0_data;
    logic          w1_en;
    logic [AW-1:0] w1_addr;
    logic [DW-1:0] w1_data;
    logic          iss_en;
    logic [AW-1:0] iss_addr;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;
    logic [AW:0]   busy_cnt;

    modport master (
        output rs_addr, rt_addr, w0_en, w0_addr, w0_data,
        output w1_en, w1_addr, w1_data, iss_en, iss_addr, dbg_addr,
        input  rs_data, rt_data, rs_busy, rt_busy, dbg_data, busy_cnt
    );

    modport slave (
        input  rs_addr, rt_addr, w0_en, w0_addr, w0_data,
        input  w1_en, w1_addr, w1_data, iss_en, iss_addr, dbg_addr,
        output rs_data, rt_data, rs_busy, rt_busy, dbg_data, busy_cnt
    );
endinterface

// File: rtl/reg_file_sb.sv
// Two-write-port register file with combinational read ports, a debug port, and a
// per-register load scoreboard whose population count is kept in a registered counter.
module reg_file_sb #(
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 5,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input logic          clk,
    input logic          rst_n,
    reg_file_sb_if.slave bus
);
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned CW    = AW + 1;

    logic [DW-1:0]    regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic [DEPTH-1:0] w0_hit;
    logic [DEPTH-1:0] w1_hit;
    logic [DEPTH-1:0] iss_hit;
    logic             w0_ok;
    logic             w1_ok;
    logic             iss_ok;
    logic             cnt_inc;
    logic             cnt_dec;
    logic [CW-1:0]    cnt_nxt;

    // Register 0 swallows every write and issue when it is hardwired.
    assign w0_ok  = bus.w0_en  && !(ZERO_REG && (bus.w0_addr  == '0));
    assign w1_ok  = bus.w1_en  && !(ZERO_REG && (bus.w1_addr  == '0));
    assign iss_ok = bus.iss_en && !(ZERO_REG && (bus.iss_addr == '0));

    always_comb begin
        w0_hit  = '0;
        w1_hit  = '0;
        iss_hit = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w0_hit[i]  = w0_ok  && (bus.w0_addr  == AW'(i));
            w1_hit[i]  = w1_ok  && (bus.w1_addr  == AW'(i));
            iss_hit[i] = iss_ok && (bus.iss_addr == AW'(i));
        end
        // Issue wins over a same-register load return: the register stays busy.
        busy_nxt = (busy & ~w1_hit) | iss_hit;
        cnt_inc  = |(iss_hit & ~busy);
        cnt_dec  = |(w1_hit & busy & ~iss_hit);
        cnt_nxt  = bus.busy_cnt + CW'(cnt_inc) - CW'(cnt_dec);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
            busy         <= '0;
            bus.busy_cnt <= '0;
        end else begin
            // ALU writeback takes priority: it belongs to the younger instruction.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (w0_hit[i])      regs[i] <= bus.w0_data;
                else if (w1_hit[i]) regs[i] <= bus.w1_data;
            end
            busy         <= busy_nxt;
            bus.busy_cnt <= cnt_nxt;
        end
    end

    function automatic logic [DW-1:0] rd_data(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        d = regs[a];
        if (BYPASS) begin
            if (w0_ok && (bus.w0_addr == a))      d = bus.w0_data;
            else if (w1_ok && (bus.w1_addr == a)) d = bus.w1_data;
        end
        if (ZERO_REG && (a == '0)) d = '0;
        return d;
    endfunction

    function automatic logic rd_busy(input logic [AW-1:0] a);
        logic b;
        b = busy[a];
        if (BYPASS && w1_ok && (bus.w1_addr == a) && !(iss_ok && (bus.iss_addr == a)))
            b = 1'b0;
        if (ZERO_REG && (a == '0)) b = 1'b0;
        return b;
    endfunction

    always_comb begin
        bus.rs_data  = rd_data(bus.rs_addr);
        bus.rt_data  = rd_data(bus.rt_addr);
        bus.rs_busy  = rd_busy(bus.rs_addr);
        bus.rt_busy  = rd_busy(bus.rt_addr);
        bus.dbg_data = (ZERO_REG && (bus.dbg_addr == '0)) ? '0 : regs[bus.dbg_addr];
    end
endmodule
